// File: rtl/matrix256_serial_capture.sv
// Receive-side capture of the Matrix256 32-bit serial chain.
// Define MATRIX_CAP_ERR_STATS_EN to add err_cnt/ghost_cnt outputs.
module matrix256_serial_capture #(
  parameter int SYNC_STAGES = 2,
  parameter int WINDOW      = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        serial_data,
  input  logic        rclk,
  input  logic        clear,
  output logic [15:0] anode,
  output logic [15:0] cathode,
  output logic        col_valid,
  output logic [3:0]  col_idx,
  output logic        latch_err,
  output logic        frame_valid,
  output logic [7:0]  frame_cnt,
  input  logic [3:0]  rd_row,
  input  logic [3:0]  rd_col,
  output logic [1:0]  rd_pix
`ifdef MATRIX_CAP_ERR_STATS_EN
  ,
  output logic [15:0] err_cnt,
  output logic [15:0] ghost_cnt
`endif
);

  localparam int WW = $clog2(WINDOW);
  localparam logic [WW-1:0] WMAX = WW'(WINDOW - 1);

  function automatic logic [4:0] pop16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
    return n;
  endfunction

  logic [SYNC_STAGES-1:0] sclk_sy_q;
  logic [SYNC_STAGES-1:0] data_sy_q;
  logic [SYNC_STAGES-1:0] rclk_sy_q;
  logic [SYNC_STAGES-1:0] clr_sy_q;
  logic sclk_pv_q, rclk_pv_q, data_pv_q;
  logic sclk_s, rclk_s, data_s, clr_s;
  logic sclk_rise, rclk_rise;

  logic [31:0] sr_q, sr_d;
  logic [5:0]  bcnt_q, bcnt_d;
  logic        first_q, first_d;

  logic [15:0][15:0][1:0] acc_q, acc_d;
  logic [15:0][15:0][1:0] frame_q, frame_d;
  logic [WW-1:0] win_q, win_d;

  logic [15:0] anode_q, cathode_q;
  logic        col_valid_q, latch_err_q, frame_valid_q;
  logic [3:0]  col_idx_q;
  logic [7:0]  frame_cnt_q;
  logic [1:0]  rd_pix_q;

  logic [15:0] lat_an, lat_ca;
  logic [3:0]  col_w;
  logic        valid, bad, pub;

  assign sclk_s    = sclk_sy_q[SYNC_STAGES-1];
  assign rclk_s    = rclk_sy_q[SYNC_STAGES-1];
  assign data_s    = data_sy_q[SYNC_STAGES-1];
  assign clr_s     = clr_sy_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_pv_q;
  assign rclk_rise = rclk_s & ~rclk_pv_q;

  // Synchronize link pins and keep one cycle of history for edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sy_q <= '0;
      data_sy_q <= '0;
      rclk_sy_q <= '0;
      clr_sy_q  <= '1;
      sclk_pv_q <= 1'b0;
      rclk_pv_q <= 1'b0;
      data_pv_q <= 1'b0;
    end else begin
      sclk_sy_q <= {sclk_sy_q[SYNC_STAGES-2:0], sclk};
      data_sy_q <= {data_sy_q[SYNC_STAGES-2:0], serial_data};
      rclk_sy_q <= {rclk_sy_q[SYNC_STAGES-2:0], rclk};
      clr_sy_q  <= {clr_sy_q[SYNC_STAGES-2:0], clear};
      sclk_pv_q <= sclk_s;
      rclk_pv_q <= rclk_s;
      data_pv_q <= data_s;
    end
  end

  // Decode the pre-shift register contents on a latch edge
  always_comb begin
    lat_an = sr_q[31:16];
    lat_ca = {<<{sr_q[15:0]}};
    col_w  = '0;
    for (int k = 0; k < 16; k++)
      if (!lat_ca[k]) col_w = 4'(k);
    valid = rclk_rise && (pop16(~lat_ca) == 5'd1) &&
            ((bcnt_q == 6'd32) || first_q);
    bad   = rclk_rise && !valid;
    pub   = valid && (win_q == WMAX);
  end

  // Shift chain: latch resets the count, a same-cycle shift follows it
  always_comb begin
    sr_d    = sr_q;
    bcnt_d  = bcnt_q;
    first_d = first_q;
    if (rclk_rise) begin
      bcnt_d  = '0;
      first_d = 1'b0;
    end
    if (sclk_rise) begin
      sr_d = {sr_q[30:0], data_pv_q};
      if (rclk_rise) bcnt_d = 6'd1;
      else if (bcnt_q != 6'd63) bcnt_d = bcnt_q + 6'd1;
    end
    if (!clr_s) begin
      sr_d    = '0;
      bcnt_d  = '0;
      first_d = 1'b1;
    end
  end

  // Per-pixel lit counts and window publication
  always_comb begin
    acc_d   = acc_q;
    frame_d = frame_q;
    win_d   = win_q;
    if (valid) begin
      for (int i = 0; i < 16; i++)
        if (lat_an[i] && acc_q[i][col_w] != 2'd3)
          acc_d[i][col_w] = acc_q[i][col_w] + 2'd1;
      if (pub) begin
        frame_d = acc_d;
        acc_d   = '0;
        win_d   = '0;
      end else begin
        win_d = win_q + 1'b1;
      end
    end
  end

  // Link state, decoded outputs and registered frame read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q          <= '0;
      bcnt_q        <= '0;
      first_q       <= 1'b1;
      acc_q         <= '0;
      frame_q       <= '0;
      win_q         <= '0;
      anode_q       <= '0;
      cathode_q     <= '0;
      col_valid_q   <= 1'b0;
      latch_err_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      col_idx_q     <= '0;
      frame_cnt_q   <= '0;
      rd_pix_q      <= '0;
    end else begin
      sr_q          <= sr_d;
      bcnt_q        <= bcnt_d;
      first_q       <= first_d;
      acc_q         <= acc_d;
      frame_q       <= frame_d;
      win_q         <= win_d;
      col_valid_q   <= valid;
      latch_err_q   <= bad;
      frame_valid_q <= pub;
      if (rclk_rise) begin
        anode_q   <= lat_an;
        cathode_q <= lat_ca;
      end
      if (valid) col_idx_q <= col_w;
      if (pub) frame_cnt_q <= frame_cnt_q + 8'd1;
      rd_pix_q <= frame_q[rd_row][rd_col];
    end
  end

  assign anode       = anode_q;
  assign cathode     = cathode_q;
  assign col_valid   = col_valid_q;
  assign col_idx     = col_idx_q;
  assign latch_err   = latch_err_q;
  assign frame_valid = frame_valid_q;
  assign frame_cnt   = frame_cnt_q;
  assign rd_pix      = rd_pix_q;

`ifdef MATRIX_CAP_ERR_STATS_EN
  logic [15:0] err_q, ghost_q;

  // Saturating error and ghosting statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q   <= '0;
      ghost_q <= '0;
    end else begin
      if (bad && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
      if (valid && pop16(lat_an) >= 5'd12 && ghost_q != 16'hFFFF)
        ghost_q <= ghost_q + 16'd1;
    end
  end

  assign err_cnt   = err_q;
  assign ghost_cnt = ghost_q;
`endif

endmodule

// File: doc/matrix256_serial_capture.md
Name: matrix256_serial_capture

Overview:
- Receive-side model of the Pmod Matrix256 serial link: the 32-bit shift-register chain that a frame-buffer driver feeds via sclk/serial_data/rclk/clear.
- Oversamples the link on the system clock, shifts and latches 32-bit words, and decodes 16 anode bits plus a one-cold 16-bit cathode column select.
- Accumulates per-pixel lit counts over 64 latches and publishes a 16x16 frame of 2-bit brightness values readable through a registered port.
- Used as a bench monitor and as an on-FPGA loopback checker.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on sclk/serial_data/rclk/clear (min 2)
- WINDOW, 64, latches per accumulation window (power of 2, >=16)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sclk  in  1  link shift clock (async)
- serial_data  in  1  link data (async)
- rclk  in  1  link latch clock (async)
- clear  in  1  link shift-register clear, active low (async)
- anode  out  16  last latched anode bits, bit i = row i
- cathode  out  16  last latched cathode bits, active low
- col_valid  out  1  one-cycle pulse: latch decoded to a single column
- col_idx  out  4  column of last valid latch
- latch_err  out  1  one-cycle pulse: cathode not one-cold, or bit count != 32
- frame_valid  out  1  one-cycle pulse: frame memory updated
- frame_cnt  out  8  frames published, wraps 255->0
- rd_row  in  4  read address row
- rd_col  in  4  read address column
- rd_pix  out  2  brightness at (rd_row, rd_col), 1-cycle latency

Behaviour:
- Reset: single clock clk; reset rst_n is asynchronous, active-low. All outputs and internal state 0; frame memory and accumulators 0; synchronizer stages initialise to 0 for data and 1 for clear.
- Edge detect: sclk/rclk rise = synchronized 0->1 between consecutive clk cycles. Link high/low times must each be >= SYNC_STAGES+1 clk.
- Shift: on sclk rise, sr <= {sr[30:0], d}, where d = synchronized serial_data one cycle before the edge detection (pre-edge value; zero-hold model). bit_cnt (6 bits, saturates at 63) increments.
- Latch: on rclk rise, decode sr as it was before any same-cycle shift. If both edges fall in one cycle, latch first, then shift; bit_cnt restarts at 1.
  - anode[i] = sr[16+i] (first bit sent = row 15).
  - cathode[k] = sr[15-k].
  - bit_cnt cleared to 0 on a non-coincident latch.
- Decode: valid iff exactly one cathode bit is 0 and bit_cnt == 32. The first latch after reset or clear is exempt from the bit_cnt check.
  - Valid: col_valid pulses and col_idx = k, registered 1 cycle after edge detection. For each row i with anode[i]=1, acc[i][k] increments, saturating at 3. win_cnt increments.
  - Invalid: latch_err pulses, accumulators and win_cnt untouched; anode/cathode outputs still update.
- Window: when win_cnt reaches WINDOW-1 and a valid latch arrives, copy acc (including this latch) to frame memory, clear acc and win_cnt, pulse frame_valid the next cycle, increment frame_cnt. A driver cycling 4 threshold passes x 16 columns yields brightness v in 0..3 per pixel, independent of window alignment.
- clear low (synchronized): sr and bit_cnt = 0, sclk edges ignored. Frame memory, accumulators and win_cnt kept.
- Read: rd_pix registered from frame memory. A read in the same cycle as the copy returns the old value.
- rst_n asserted mid-word: immediate clear of all state; first post-reset latch exempt as above.

Optional Feature:
- MATRIX_CAP_ERR_STATS_EN defined: adds outputs err_cnt [15:0] (saturating count of latch_err) and ghost_cnt [15:0] (saturating count of valid latches whose anode is all-ones on >=12 rows), both cleared by rst_n only.
- Undefined: ports and logic absent; remaining behaviour identical.

Test Plan:
- Single word: shift 32 bits with anode=16'h8001, cathode=16'hFFFB, then rclk -> col_valid, col_idx=2, anode=8001, no latch_err.
- Full frame: drive 64 words (passes 0..3 x columns 0..15) from an image with pixel(5,7)=3, (0,0)=1, others 0 -> frame_valid once; rd_pix(5,7)=3, (0,0)=1, (15,15)=0 one cycle after address; frame_cnt=1.
- Bad words: cathode=16'hFFFF, then cathode=16'hFFF3, then only 31 bits before rclk -> three latch_err pulses, win_cnt unchanged, no frame_valid.
- Coincident edges: sclk and rclk rising in the same clk cycle -> latch uses pre-shift sr, new bit becomes sr[0], bit_cnt=1.
- Misaligned start: begin capture at pass 2 column 9, 128 words total -> frame contents equal source image both frames.
- Reset/clear mid-word: clear low after 10 bits, then full word -> valid decode. rst_n low mid-frame -> all outputs 0, frame_cnt=0.
